// File: rtl/fifo_wrptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wrptr_full
//
// Write-side pointer and status logic for an asynchronous FIFO. Keeps the
// binary write pointer, publishes its Gray-coded copy to the read domain,
// brings the read domain's Gray pointer across with a two-flop synchroniser,
// and derives full, almost-full, fill level and a sticky overflow flag.
//
// Parameters
//   WIDTH     data width of the companion memory (sanity-checked only)
//   DEPTH     number of FIFO entries, power of two, >= 4
//   AFULL_TH  fill level at which WAFULL asserts, 1..DEPTH
//
// Ports
//   W_CLK      in   write-domain clock
//   W_RST      in   asynchronous active-low reset
//   W_INC      in   write request for this cycle
//   OVF_CLR    in   synchronous clear of WOVF
//   gray_Rptr  in   Gray read pointer from the read domain (asynchronous)
//   W_EN       out  memory write strobe
//   Waddr      out  memory write address
//   gray_Wptr  out  registered Gray write pointer for the read domain
//   WFULL      out  FIFO full
//   WAFULL     out  FIFO almost full
//   WOVF       out  sticky: write attempted while full
//   Wlevel     out  write-side fill estimate, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_wrptr_full #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          W_CLK,
    input  logic          W_RST,
    input  logic          W_INC,
    input  logic          OVF_CLR,
    input  logic [AW:0]   gray_Rptr,
    output logic          W_EN,
    output logic [AW-1:0] Waddr,
    output logic [AW:0]   gray_Wptr,
    output logic          WFULL,
    output logic          WAFULL,
    output logic          WOVF,
    output logic [AW:0]   Wlevel
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_wrptr_full: DEPTH must be a power of two and at least 4");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_wrptr_full: AFULL_TH must lie in 1..DEPTH");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_wrptr_full: WIDTH must be at least 1");
    end

    localparam logic [AW:0] AFULL_LVL = (AW + 1)'(AFULL_TH);

    logic [AW:0] rq1;
    logic [AW:0] rq2;
    logic [AW:0] wptr;
    logic [AW:0] wptr_next;
    logic [AW:0] rsync_bin;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Read pointer synchroniser: plain flop-to-flop, nothing in between.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= gray_Rptr;
            rq2 <= rq1;
        end
    end

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        rsync_bin = '0;
        for (int i = 0; i <= AW; i++) begin
            rsync_bin[i] = ^(rq2 >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the synchronised
    // read pointer; in Gray code that means the top two bits differ and the
    // rest match. Using the stale rq2 can only make full look longer, never
    // shorter.
    assign WFULL     = (gray_Wptr == {~rq2[AW:AW-1], rq2[AW-2:0]});
    assign W_EN      = W_INC & ~WFULL;
    assign wptr_next = wptr + (AW + 1)'(1);
    assign Waddr     = wptr[AW-1:0];
    assign Wlevel    = wptr - rsync_bin;
    assign WAFULL    = (Wlevel >= AFULL_LVL);

    // Binary pointer and its Gray copy move together so the read domain never
    // sees a pointer that disagrees with the memory write just performed.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wptr      <= '0;
            gray_Wptr <= '0;
        end else if (W_EN) begin
            wptr      <= wptr_next;
            gray_Wptr <= bin2gray(wptr_next);
        end
    end

    // Sticky overflow; a new overflow on the clearing edge takes priority.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            WOVF <= 1'b0;
        end else if (W_INC && WFULL) begin
            WOVF <= 1'b1;
        end else if (OVF_CLR) begin
            WOVF <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wrptr_full.sv
// -----------------------------------------------------------------------------
// tb_fifo_wrptr_full
//
// Scoreboard bench for fifo_wrptr_full (DEPTH=16, AFULL_TH=14). The reference
// model counts accepted writes and reads as unbounded integers; the read count
// reaches the write side through a two-deep delay line. Expected outputs are
// queued each cycle and a separate monitor compares them at the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wrptr_full;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int AFULL_TH = 14;
    localparam int PW       = 2 * DEPTH;

    logic          W_CLK = 1'b0;
    logic          W_RST = 1'b1;
    logic          W_INC = 1'b0;
    logic          OVF_CLR = 1'b0;
    logic [AW:0]   gray_Rptr = '0;
    logic          W_EN;
    logic [AW-1:0] Waddr;
    logic [AW:0]   gray_Wptr;
    logic          WFULL;
    logic          WAFULL;
    logic          WOVF;
    logic [AW:0]   Wlevel;

    fifo_wrptr_full #(
        .WIDTH    (8),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .W_CLK     (W_CLK),
        .W_RST     (W_RST),
        .W_INC     (W_INC),
        .OVF_CLR   (OVF_CLR),
        .gray_Rptr (gray_Rptr),
        .W_EN      (W_EN),
        .Waddr     (Waddr),
        .gray_Wptr (gray_Wptr),
        .WFULL     (WFULL),
        .WAFULL    (WAFULL),
        .WOVF      (WOVF),
        .Wlevel    (Wlevel)
    );

    bit clk_run = 1'b0;
    always begin
        #5;
        if (clk_run) W_CLK = ~W_CLK;
    end

    typedef struct {
        bit en;
        int waddr;
        int gwptr;
        bit full;
        bit afull;
        bit ovf;
        int level;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state.
    int wr_total = 0;
    int rd_total = 0;
    int seen1    = 0;
    int seen2    = 0;
    bit ovf_m    = 1'b0;

    function automatic int gray_of(input int n);
        int b;
        b = n % PW;
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t predict(input bit inc);
        exp_t e;
        int   lvl;
        lvl     = wr_total - seen2;
        e.level = lvl;
        e.full  = (lvl == DEPTH);
        e.en    = inc && !e.full;
        e.waddr = wr_total % DEPTH;
        e.gwptr = gray_of(wr_total);
        e.afull = (lvl >= AFULL_TH);
        e.ovf   = ovf_m;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: compares whatever has been queued at each falling edge, or
    // immediately when an asynchronous check is requested.
    initial begin
        exp_t e;
        forever begin
            @(negedge W_CLK or chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("w_en",      32'(W_EN),      int'(e.en));
                chk("waddr",     32'(Waddr),     e.waddr);
                chk("gray_wptr", 32'(gray_Wptr), e.gwptr);
                chk("wfull",     32'(WFULL),     int'(e.full));
                chk("wafull",    32'(WAFULL),    int'(e.afull));
                chk("wovf",      32'(WOVF),      int'(e.ovf));
                chk("wlevel",    32'(Wlevel),    e.level);
            end
        end
    end

    // One write-domain cycle: called at posedge+1, applies inputs, queues the
    // expected outputs for this cycle, then advances the model across the edge.
    task automatic drive(input bit inc, input bit clr);
        exp_t e;
        W_INC     = inc;
        OVF_CLR   = clr;
        gray_Rptr = (AW + 1)'(gray_of(rd_total));
        e = predict(inc);
        sb.push_back(e);
        @(posedge W_CLK);
        if (inc && e.full) ovf_m = 1'b1;
        else if (clr)      ovf_m = 1'b0;
        if (e.en) wr_total++;
        seen2 = seen1;
        seen1 = rd_total;
        #1;
    endtask

    // Assert reset and check outputs without waiting for any clock edge.
    task automatic reset_check_now();
        W_INC     = 1'b0;
        OVF_CLR   = 1'b0;
        rd_total  = 0;
        gray_Rptr = '0;
        W_RST     = 1'b0;
        wr_total  = 0;
        seen1     = 0;
        seen2     = 0;
        ovf_m     = 1'b0;
        #1;
        sb.push_back(predict(1'b0));
        ->chk_ev;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with the clock stopped.
        #2;
        reset_check_now();
        #2;
        W_RST   = 1'b1;
        clk_run = 1'b1;
        @(posedge W_CLK);
        #1;

        // Fill from empty, then observe the full state.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);

        // Overflow, stickiness, set-wins-over-clear, then clear.
        drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);

        // Drain visibility: one read, seen two edges later.
        rd_total = 1;
        repeat (3) drive(1'b0, 1'b0);

        // Let the reader catch up to three behind.
        while (rd_total < wr_total - 3) begin
            rd_total++;
            drive(1'b0, 1'b0);
        end

        // Wrap: 40 writes with the reader three entries behind.
        for (int i = 0; i < 40; i++) begin
            rd_total = wr_total - 3;
            drive(1'b1, 1'b0);
            chk("wrap_no_full",  32'(WFULL), 0);
            chk("wrap_level_le5", 32'(Wlevel <= 5), 1);
        end

        // Build up to level 9 with overflow set, then reset mid-operation.
        for (int k = 0; k < 40 && (wr_total - seen2) < DEPTH; k++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        repeat (7) begin
            rd_total++;
            drive(1'b0, 1'b0);
        end
        repeat (2) drive(1'b0, 1'b0);
        reset_check_now();
        repeat (2) @(posedge W_CLK);
        #1;
        W_RST = 1'b1;
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);

        // Randomised traffic.
        repeat (600) begin
            bit inc;
            bit clr;
            inc = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 9) == 0);
            if (rd_total < wr_total && $urandom_range(0, 9) < 4) rd_total++;
            drive(inc, clr);
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
